// File: rtl/ir_decode_pkg.sv
// ir_decode_pkg: default sizes, opcode encodings and decode helpers for the decode stage
package ir_decode_pkg;
  localparam int WORD_SIZE_D = 16;
  localparam int REG_ADDR_SIZE_D = 3;
  localparam int OPCODE_SIZE_D = 5;
  localparam int ALU_OP_SIZE_D = 3;
  typedef enum logic [OPCODE_SIZE_D-1:0] {
    OP_BL      = 5'b10100,
    OP_STORE_R = 5'b11001,
    OP_STORE   = 5'b11101,
    OP_BR      = 5'b11111
  } opcode_e;
  function automatic logic writes_reg_f(logic [OPCODE_SIZE_D-1:0] op);
    return !(op inside {OP_BR, OP_STORE, OP_STORE_R});
  endfunction
endpackage

// File: rtl/ir_decode_if.sv
// ir_decode_if: fetch-side, execute-side and writeback signals of the decode stage
interface ir_decode_if #(
  parameter int WORD_SIZE = ir_decode_pkg::WORD_SIZE_D,
  parameter int REG_ADDR_SIZE = ir_decode_pkg::REG_ADDR_SIZE_D,
  parameter int OPCODE_SIZE = ir_decode_pkg::OPCODE_SIZE_D,
  parameter int ALU_OP_SIZE = ir_decode_pkg::ALU_OP_SIZE_D
);
  logic in_valid;
  logic in_ready;
  logic [WORD_SIZE-1:0] instruction;
  logic out_valid;
  logic out_ready;
  logic [REG_ADDR_SIZE-1:0] reg_addr1;
  logic [REG_ADDR_SIZE-1:0] reg_addr2;
  logic [REG_ADDR_SIZE-1:0] reg_addr_in;
  logic writes_reg;
  logic [WORD_SIZE-OPCODE_SIZE-1:0] imm1;
  logic [WORD_SIZE-OPCODE_SIZE-REG_ADDR_SIZE-1:0] imm2;
  logic [WORD_SIZE-OPCODE_SIZE-2*REG_ADDR_SIZE-1:0] imm3;
  logic [ALU_OP_SIZE-1:0] alu_op;
  logic [OPCODE_SIZE-1:0] opcode;
  logic wb_valid;
  logic [REG_ADDR_SIZE-1:0] wb_addr;
  logic flush;
  logic stall;
  modport slave (
    input in_valid, instruction, out_ready, wb_valid, wb_addr, flush,
    output in_ready, out_valid, reg_addr1, reg_addr2, reg_addr_in, writes_reg,
    output imm1, imm2, imm3, alu_op, opcode, stall
  );
  modport master (
    output in_valid, instruction, out_ready, wb_valid, wb_addr, flush,
    input in_ready, out_valid, reg_addr1, reg_addr2, reg_addr_in, writes_reg,
    input imm1, imm2, imm3, alu_op, opcode, stall
  );
endinterface

// File: rtl/ir_scoreboard.sv
// ir_scoreboard: pending-write bits per register with hazard lookup for two sources and a destination
module ir_scoreboard #(
  parameter int REG_ADDR_SIZE = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic set_en,
  input  logic [REG_ADDR_SIZE-1:0] set_addr,
  input  logic clr_en,
  input  logic [REG_ADDR_SIZE-1:0] clr_addr,
  input  logic fl_en,
  input  logic [REG_ADDR_SIZE-1:0] fl_addr,
  input  logic [REG_ADDR_SIZE-1:0] src1,
  input  logic [REG_ADDR_SIZE-1:0] src2,
  input  logic [REG_ADDR_SIZE-1:0] dst,
  input  logic dst_en,
  output logic hazard
);
  localparam int N = 2**REG_ADDR_SIZE;
  logic [N-1:0] pend, clr_mask, fl_mask, set_mask, live;
  always_comb begin
    clr_mask = clr_en ? N'(1) << clr_addr : '0;
    fl_mask = fl_en ? N'(1) << fl_addr : '0;
    set_mask = set_en ? N'(1) << set_addr : '0;
    // writeback retiring this cycle already unblocks this cycle's lookup
    live = pend & ~clr_mask;
    hazard = live[src1] | live[src2] | (dst_en & live[dst]);
  end
  always_ff @(posedge clk)
    pend <= reset ? '0 : (pend & ~clr_mask & ~fl_mask) | set_mask;
endmodule

// File: rtl/ir_decode_stage.sv
// ir_decode_stage: registers and splits one instruction per cycle, stalling on in-flight register writes
module ir_decode_stage import ir_decode_pkg::*; #(
  parameter int WORD_SIZE = WORD_SIZE_D,
  parameter int REG_ADDR_SIZE = REG_ADDR_SIZE_D,
  parameter int OPCODE_SIZE = OPCODE_SIZE_D,
  parameter int ALU_OP_SIZE = ALU_OP_SIZE_D,
  parameter int LR_ADDR = 2**REG_ADDR_SIZE-1
) (
  input logic clk,
  input logic reset,
  ir_decode_if.slave bus
);
  localparam int R = REG_ADDR_SIZE;
  localparam int IMM_MSB = WORD_SIZE-OPCODE_SIZE-1;
  logic [OPCODE_SIZE-1:0] op;
  logic [R-1:0] ra, rb, rc, src1, src2, dst;
  logic wr, sb_hazard, hazard, accept, fl_clr;
  always_comb begin
    op = bus.instruction[WORD_SIZE-1 -: OPCODE_SIZE];
    ra = bus.instruction[R-1:0];
    rb = bus.instruction[2*R-1:R];
    rc = bus.instruction[3*R-1:2*R];
    src1 = (op == OP_BR || op == OP_STORE) ? ra : rb;
    src2 = op == OP_STORE_R ? ra : rc;
    dst = op == OP_BL ? R'(LR_ADDR) : ra;
    wr = writes_reg_f(op);
  end
  assign hazard = bus.in_valid && sb_hazard;
  assign bus.stall = hazard;
  assign bus.in_ready = !reset && !bus.flush && !hazard && (!bus.out_valid || bus.out_ready);
  assign accept = bus.in_valid && bus.in_ready;
  // a flushed bundle never issued, so its destination is no longer in flight
  assign fl_clr = bus.flush && bus.out_valid && bus.writes_reg;
  ir_scoreboard #(.REG_ADDR_SIZE(R)) u_sb (
    .clk(clk),
    .reset(reset),
    .set_en(accept && wr),
    .set_addr(dst),
    .clr_en(bus.wb_valid),
    .clr_addr(bus.wb_addr),
    .fl_en(fl_clr),
    .fl_addr(bus.reg_addr_in),
    .src1(src1),
    .src2(src2),
    .dst(dst),
    .dst_en(wr),
    .hazard(sb_hazard)
  );
  always_ff @(posedge clk)
    if (reset) begin
      bus.out_valid <= 1'b0;
      bus.reg_addr1 <= '0;
      bus.reg_addr2 <= '0;
      bus.reg_addr_in <= '0;
      bus.writes_reg <= 1'b0;
      bus.imm1 <= '0;
      bus.imm2 <= '0;
      bus.imm3 <= '0;
      bus.alu_op <= '0;
      bus.opcode <= '0;
    end else if (accept) begin
      bus.out_valid <= 1'b1;
      bus.reg_addr1 <= src1;
      bus.reg_addr2 <= src2;
      bus.reg_addr_in <= dst;
      bus.writes_reg <= wr;
      bus.imm1 <= bus.instruction[IMM_MSB:0];
      bus.imm2 <= bus.instruction[IMM_MSB:R];
      bus.imm3 <= bus.instruction[IMM_MSB:2*R];
      bus.alu_op <= op[ALU_OP_SIZE-1:0];
      bus.opcode <= op;
    end else if (bus.flush || bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
endmodule

// File: tb/tb_ir_decode_stage.sv
// tb_ir_decode_stage: directed plus random stimulus against a queue-based reference model
module tb_ir_decode_stage;
  typedef logic [41:0] bundle_t;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int fails = 0;
  bundle_t q[$];
  bit pm[8];
  bit held = 0;
  bit held_wr = 0;
  int held_dst = 0;
  bit after_reset = 0;
  always #5 clk = ~clk;
  ir_decode_if bus ();
  ir_decode_stage dut (.clk(clk), .reset(reset), .bus(bus));
  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic bundle_t dut_bundle();
    return {bus.reg_addr1, bus.reg_addr2, bus.reg_addr_in, bus.writes_reg, bus.imm1,
            bus.imm2, bus.imm3, bus.alu_op, bus.opcode};
  endfunction
  function automatic bundle_t model_decode(int instr, output int s1, output int s2,
                                           output int dst, output bit wr);
    int op, ra, rb, rc;
    op = (instr >> 11) & 31;
    ra = instr & 7;
    rb = (instr >> 3) & 7;
    rc = (instr >> 6) & 7;
    s1 = (op == 31 || op == 29) ? ra : rb;
    s2 = (op == 25) ? ra : rc;
    dst = (op == 20) ? 7 : ra;
    wr = !(op == 31 || op == 29 || op == 25);
    return {3'(s1), 3'(s2), 3'(dst), wr, 11'(instr & 'h7ff), 8'((instr >> 3) & 'hff),
            5'((instr >> 6) & 'h1f), 3'(op & 7), 5'(op)};
  endfunction
  function automatic bit live(int a, bit wbv, int wba);
    return pm[a] && !(wbv && wba == a);
  endfunction
  task automatic cycle(bit iv, int instr, bit ordy, bit wbv, int wba, bit fl, bit rs);
    int s1, s2, dst;
    bit wr, hz, er, acc;
    bundle_t b;
    @(negedge clk);
    reset = rs;
    bus.in_valid = iv;
    bus.instruction = 16'(instr);
    bus.out_ready = ordy;
    bus.wb_valid = wbv;
    bus.wb_addr = 3'(wba);
    bus.flush = fl;
    #1;
    b = model_decode(instr, s1, s2, dst, wr);
    hz = iv && (live(s1, wbv, wba) || live(s2, wbv, wba) || (wr && live(dst, wbv, wba)));
    er = !rs && !fl && !hz && (!held || ordy);
    check("in_ready", bus.in_ready, er);
    check("stall", bus.stall, hz);
    check("out_valid", bus.out_valid, held);
    if (after_reset) check("reset_fields", dut_bundle(), 0);
    acc = iv && er;
    @(posedge clk);
    if (rs) begin
      foreach (pm[i]) pm[i] = 0;
      held = 0;
      q.delete();
    end else begin
      if (wbv) pm[wba] = 0;
      if (fl && held) begin
        if (held_wr) pm[held_dst] = 0;
        void'(q.pop_back());
        held = 0;
      end else if (held && ordy) held = 0;
      if (acc) begin
        if (wr) pm[dst] = 1;
        q.push_back(b);
        held = 1;
        held_dst = dst;
        held_wr = wr;
      end
    end
    after_reset = rs;
  endtask
  initial forever begin
    @(negedge clk);
    #2;
    if (bus.out_valid === 1'b1 && bus.out_ready && !bus.flush && !reset) begin
      if (q.size() == 0) check("out_valid_unexpected", bus.out_valid, 0);
      else check("bundle", dut_bundle(), q.pop_front());
    end
  end
  initial begin
    int op, instr;
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.instruction = '0;
    bus.out_ready = 1'b0;
    bus.wb_valid = 1'b0;
    bus.wb_addr = '0;
    bus.flush = 1'b0;
    cycle(0, 0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 0, 1);
    cycle(1, 'h00D1, 1, 0, 0, 0, 0);
    cycle(1, 'h0008, 1, 0, 0, 0, 0);
    cycle(1, 'h0008, 1, 1, 1, 0, 0);
    cycle(0, 0, 1, 1, 0, 0, 0);
    cycle(1, 'hA005, 1, 0, 0, 0, 0);
    cycle(1, 'hF807, 1, 0, 0, 0, 0);
    cycle(1, 'hF807, 1, 0, 0, 0, 0);
    cycle(1, 'hF807, 1, 1, 7, 0, 0);
    cycle(1, 'hC8D1, 1, 0, 0, 0, 0);
    cycle(1, 'hE8D1, 1, 0, 0, 0, 0);
    cycle(1, 'h00D1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0, 0);
    cycle(1, 'h0008, 0, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 0, 1, 0);
    cycle(1, 'h0008, 1, 0, 0, 0, 0);
    cycle(1, 'h00D1, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 1);
    cycle(1, 'h0008, 1, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 7))
        0: op = 31;
        1: op = 29;
        2: op = 25;
        3: op = 20;
        default: op = int'($urandom_range(0, 31));
      endcase
      instr = (op << 11) | int'($urandom_range(0, 2047));
      cycle($urandom_range(0, 3) != 0, instr, $urandom_range(0, 9) < 7,
            $urandom_range(0, 2) == 0, int'($urandom_range(0, 7)),
            $urandom_range(0, 19) == 0, $urandom_range(0, 99) == 0);
    end
    cycle(0, 0, 1, 0, 0, 0, 0);
    #10;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
